// File: rtl/jtkicker_vtgen_if.sv
// Video timing bus between jtkicker_vtgen and its consumers.
// The generator side (master) receives the pixel enable and the sync
// centring offsets, and drives the counters, blanking, sync and irq.
interface jtkicker_vtgen_if;
   logic       pxl_cen;
   logic [3:0] hoffset;
   logic [3:0] voffset;
   logic [8:0] hdump;
   logic [8:0] vdump;
   logic [8:0] vrender;
   logic [8:0] vrender1;
   logic       hinit;
   logic       vinit;
   logic       LHBL;
   logic       LVBL;
   logic       HS;
   logic       VS;
   logic       irq;
   logic       field;

   modport master (
      input  pxl_cen, hoffset, voffset,
      output hdump, vdump, vrender, vrender1, hinit, vinit,
             LHBL, LVBL, HS, VS, irq, field
   );

   modport slave (
      output pxl_cen, hoffset, voffset,
      input  hdump, vdump, vrender, vrender1, hinit, vinit,
             LHBL, LVBL, HS, VS, irq, field
   );
endinterface

// File: rtl/jtkicker_vtgen.sv
// Parametrised video timing generator.
// H/V counters advance on pxl_cen. Blanking, sync, render-ahead line counts,
// field and the line interrupt are all registered and change only on the clk
// edge that follows a pxl_cen. Sync centring offsets are sampled into shadow
// registers on the last pixel of the frame so a frame never sees a torn sync.
module jtkicker_vtgen #(
   parameter logic [8:0] HCNT_END      = 9'd383,
   parameter logic [8:0] HB_START      = 9'd255,
   parameter logic [8:0] HB_END        = 9'd383,
   parameter logic [8:0] HS_START      = 9'd300,
   parameter logic [8:0] HS_END        = 9'd318,
   parameter logic [8:0] VCNT_END      = 9'd263,
   parameter logic [8:0] VB_START      = 9'd238,
   parameter logic [8:0] VB_END        = 9'd15,
   parameter logic [8:0] VS_START      = 9'd254,
   parameter logic [8:0] VS_END        = 9'd2,
   parameter logic [1:0] VRENDER_AHEAD = 2'd1,
   parameter logic       H7_BLANK      = 1'b1,
   parameter logic [8:0] IRQ_LINE      = 9'd239
) (
   input  logic              clk,
   input  logic              rst_n,
   jtkicker_vtgen_if.master  vt
);

   // Adds a signed 4-bit offset to a nominal position and folds the result
   // back into [0, cnt_end]. Offsets are small, so one correction is enough.
   function automatic logic [8:0] wrap_offset(input logic [8:0] base,
                                              input logic [3:0] off,
                                              input logic [8:0] cnt_end);
      logic signed [10:0] sum;
      logic signed [10:0] len;
      logic signed [10:0] res;
      sum = $signed({2'b00, base}) + $signed({{7{off[3]}}, off});
      len = $signed({2'b00, cnt_end}) + 11'sd1;
      if (sum < 11'sd0) begin
         res = sum + len;
      end else if (sum > $signed({2'b00, cnt_end})) begin
         res = sum - len;
      end else begin
         res = sum;
      end
      return res[8:0];
   endfunction

   // Line number k lines after v, modulo the frame length.
   function automatic logic [8:0] vmod_add(input logic [8:0] v, input logic [2:0] k);
      logic [9:0] s;
      s = {1'b0, v} + {7'd0, k};
      if (s > {1'b0, VCNT_END}) begin
         s = s - ({1'b0, VCNT_END} + 10'd1);
      end else begin
         s = s;
      end
      return s[8:0];
   endfunction

   // hdump encoding: optionally hold bit 7 high during the H[8] half.
   function automatic logic [8:0] hdump_enc(input logic [8:0] h);
      if (H7_BLANK) begin
         return {h[8], h[7] | h[8], h[6:0]};
      end else begin
         return h;
      end
   endfunction

   localparam logic [2:0] AHEAD0 = {1'b0, VRENDER_AHEAD};
   localparam logic [2:0] AHEAD1 = {1'b0, VRENDER_AHEAD} + 3'd1;

   logic [8:0] r_h;
   logic [8:0] r_v;
   logic [8:0] r_hdump;
   logic [8:0] r_vrender;
   logic [8:0] r_vrender1;
   logic [3:0] r_hoff;
   logic [3:0] r_voff;
   logic       r_lhbl;
   logic       r_lvbl;
   logic       r_hs;
   logic       r_vs;
   logic       r_irq;
   logic       r_field;

   logic       w_h_last;
   logic       w_v_last;
   logic [8:0] w_h_nxt;
   logic [8:0] w_v_nxt;
   logic [8:0] w_hs_on;
   logic [8:0] w_hs_off;
   logic [8:0] w_vs_on;
   logic [8:0] w_vs_off;

   // Next counter values and the frame's effective sync points.
   always_comb begin
      w_h_last = (r_h == HCNT_END);
      w_v_last = (r_v == VCNT_END);
      w_h_nxt  = 9'd0;
      w_v_nxt  = r_v;
      if (w_h_last) begin
         w_h_nxt = 9'd0;
         if (w_v_last) begin
            w_v_nxt = 9'd0;
         end else begin
            w_v_nxt = r_v + 9'd1;
         end
      end else begin
         w_h_nxt = r_h + 9'd1;
         w_v_nxt = r_v;
      end
      w_hs_on  = wrap_offset(HS_START, r_hoff, HCNT_END);
      w_hs_off = wrap_offset(HS_END,   r_hoff, HCNT_END);
      w_vs_on  = wrap_offset(VS_START, r_voff, VCNT_END);
      w_vs_off = wrap_offset(VS_END,   r_voff, VCNT_END);
   end

   // Counters, blanking, sync, irq and field, all advancing on pxl_cen.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_h        <= 9'd0;
         r_v        <= 9'd0;
         r_hdump    <= 9'd0;
         r_vrender  <= vmod_add(9'd0, AHEAD0);
         r_vrender1 <= vmod_add(9'd0, AHEAD1);
         r_hoff     <= 4'd0;
         r_voff     <= 4'd0;
         r_lhbl     <= 1'b0;
         r_lvbl     <= 1'b0;
         r_hs       <= 1'b0;
         r_vs       <= 1'b0;
         r_irq      <= 1'b0;
         r_field    <= 1'b0;
      end else begin
         r_irq <= 1'b0;
         if (vt.pxl_cen) begin
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
            r_hdump <= hdump_enc(w_h_nxt);
            r_irq   <= (w_h_nxt == 9'd0) && (w_v_nxt == IRQ_LINE);

            if (r_h == HB_START) begin
               r_lhbl <= 1'b0;
            end else if (r_h == HB_END) begin
               r_lhbl <= 1'b1;
            end

            // "off" is tested first so coincident points leave sync low
            if (r_h == w_hs_off) begin
               r_hs <= 1'b0;
            end else if (r_h == w_hs_on) begin
               r_hs <= 1'b1;
            end

            if (r_h == w_hs_on) begin
               if (r_v == w_vs_off) begin
                  r_vs <= 1'b0;
               end else if (r_v == w_vs_on) begin
                  r_vs <= 1'b1;
               end
            end

            if (w_h_last) begin
               r_vrender  <= vmod_add(w_v_nxt, AHEAD0);
               r_vrender1 <= vmod_add(w_v_nxt, AHEAD1);
               if (r_v == VB_START) begin
                  r_lvbl <= 1'b0;
               end else if (r_v == VB_END) begin
                  r_lvbl <= 1'b1;
               end
               if (w_v_last) begin
                  r_field <= ~r_field;
                  r_hoff  <= vt.hoffset;
                  r_voff  <= vt.voffset;
               end
            end
         end
      end
   end

   assign vt.hdump    = r_hdump;
   assign vt.vdump    = r_v;
   assign vt.vrender  = r_vrender;
   assign vt.vrender1 = r_vrender1;
   assign vt.hinit    = w_h_last;
   assign vt.vinit    = w_h_last & w_v_last;
   assign vt.LHBL     = r_lhbl;
   assign vt.LVBL     = r_lvbl;
   assign vt.HS       = r_hs;
   assign vt.VS       = r_vs;
   assign vt.irq      = r_irq;
   assign vt.field    = r_field;

endmodule

// File: tb/tb_jtkicker_vtgen.sv
// Randomized bench for jtkicker_vtgen. The reference model tracks a single
// pixel count since reset and derives H, V, field and render lines from it
// arithmetically; blanking/sync flags follow the set/clear rules per pixel.
// A short frame (20 lines) keeps whole-frame behaviour within the run time.
module tb_jtkicker_vtgen;
   localparam int HL    = 384;
   localparam int VL    = 20;
   localparam int FR    = HL * VL;
   localparam int HBS   = 255;
   localparam int HBE   = 383;
   localparam int HSS   = 300;
   localparam int HSE   = 318;
   localparam int VBS   = 16;
   localparam int VBE   = 2;
   localparam int VSS   = 17;
   localparam int VSE   = 2;
   localparam int AHEAD = 2;
   localparam int IRQL  = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jtkicker_vtgen_if vif();

   jtkicker_vtgen #(
      .VCNT_END(9'd19), .VB_START(9'd16), .VB_END(9'd2),
      .VS_START(9'd17), .VS_END(9'd2), .VRENDER_AHEAD(2'd2),
      .IRQ_LINE(9'd15)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .vt    (vif.master)
   );

   int n_vec = 0;
   int n_err = 0;

   // model state
   int n = 0;
   bit m_lhbl, m_lvbl, m_hs, m_vs, m_irq;
   int m_hoff, m_voff;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t n=%0d: got %0d expected %0d", tag, $time, n, got, exp);
      end
   endtask

   function automatic int wrapm(input int x, input int len);
      return ((x % len) + len) % len;
   endfunction

   task automatic model_step();
      int h, v, hon, hoff, von, voff;
      if (!rst_n) begin
         n = 0; m_lhbl = 0; m_lvbl = 0; m_hs = 0; m_vs = 0; m_irq = 0;
         m_hoff = 0; m_voff = 0;
      end else if (vif.pxl_cen) begin
         h = n % HL;
         v = (n / HL) % VL;
         hon  = wrapm(HSS + m_hoff, HL);
         hoff = wrapm(HSE + m_hoff, HL);
         von  = wrapm(VSS + m_voff, VL);
         voff = wrapm(VSE + m_voff, VL);
         if (h == HBS) m_lhbl = 0; else if (h == HBE) m_lhbl = 1;
         if (h == HL - 1) begin
            if (v == VBS) m_lvbl = 0; else if (v == VBE) m_lvbl = 1;
         end
         if (h == hoff) m_hs = 0; else if (h == hon) m_hs = 1;
         if (h == hon) begin
            if (v == voff) m_vs = 0; else if (v == von) m_vs = 1;
         end
         if (h == HL - 1 && v == VL - 1) begin
            m_hoff = int'($signed(vif.hoffset));
            m_voff = int'($signed(vif.voffset));
         end
         n++;
         m_irq = ((n % HL) == 0) && (((n / HL) % VL) == IRQL);
      end else begin
         m_irq = 0;
      end
   endtask

   task automatic check_all();
      int h, v;
      h = n % HL;
      v = (n / HL) % VL;
      chk("hdump",    32'(vif.hdump),    (h >= 256) ? (h | 128) : h);
      chk("vdump",    32'(vif.vdump),    v);
      chk("vrender",  32'(vif.vrender),  (v + AHEAD) % VL);
      chk("vrender1", 32'(vif.vrender1), (v + AHEAD + 1) % VL);
      chk("hinit",    32'(vif.hinit),    32'(h == HL - 1));
      chk("vinit",    32'(vif.vinit),    32'(h == HL - 1 && v == VL - 1));
      chk("LHBL",     32'(vif.LHBL),     32'(m_lhbl));
      chk("LVBL",     32'(vif.LVBL),     32'(m_lvbl));
      chk("HS",       32'(vif.HS),       32'(m_hs));
      chk("VS",       32'(vif.VS),       32'(m_vs));
      chk("irq",      32'(vif.irq),      32'(m_irq));
      chk("field",    32'(vif.field),    (n / FR) % 2);
   endtask

   task automatic cycle(input bit r, input bit c);
      rst_n = r;
      vif.pxl_cen = c;
      @(posedge clk);
      #1;
      model_step();
      check_all();
   endtask

   // run with random pxl_cen until the model reaches pixel count 'target'
   task automatic run_to(input int target);
      for (int i = 0; i < target * 3 && n < target && n_err < 40; i++) begin
         cycle(1'b1, $urandom_range(0, 3) != 0);
      end
   endtask

   initial begin
      vif.pxl_cen = 1'b0;
      vif.hoffset = 4'd0;
      vif.voffset = 4'd0;

      // reset with pxl_cen toggling
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'($urandom_range(0, 1)));

      // first frame with nominal sync, then offsets written mid-frame
      run_to(FR / 2);
      vif.hoffset = 4'd3;
      vif.voffset = 4'hD;
      run_to(FR + FR / 2);
      vif.hoffset = 4'h8;
      run_to(2 * FR + 1000);

      // pxl_cen held low: nothing may move, no irq
      for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0);

      // reset mid-frame
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'($urandom_range(0, 1)));

      // random offsets, changed every few hundred pixels
      for (int k = 1; k <= 18 && n_err < 40; k++) begin
         vif.hoffset = 4'($urandom_range(0, 15));
         vif.voffset = 4'($urandom_range(0, 15));
         run_to(k * 500);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/jtkicker_vtgen.md
# jtkicker_vtgen

Parametrised video timing generator for Konami-era cores. Produces horizontal/vertical counters, render-ahead line counts, blanking, sync and a per-frame line interrupt from one pixel clock enable. Adds runtime sync centring offsets (latched per frame), optional "H7 held during HBLANK" hdump encoding and a programmable line IRQ. Sits between the clock-enable generator and the tile/object renderers and video output.

## Interface
- HCNT_END, 9'd383: last H count; line length HCNT_END+1 pixels
- HB_START, 9'd255: H value at which LHBL is cleared
- HB_END, 9'd383: H value at which LHBL is set
- HS_START, 9'd300: nominal H value at which HS rises
- HS_END, 9'd318: nominal H value at which HS falls
- VCNT_END, 9'd263: last V count; frame length VCNT_END+1 lines
- VB_START, 9'd238: V value at which LVBL is cleared
- VB_END, 9'd15: V value at which LVBL is set
- VS_START, 9'd254: nominal line where VS rises
- VS_END, 9'd2: nominal line where VS falls
- VRENDER_AHEAD, 2'd1: line lead of vrender over vdump (1..3)
- H7_BLANK, 1'b1: 1 = hdump[7] forced high while H[8]=1
- IRQ_LINE, 9'd239: line whose H=0 raises irq

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pxl_cen  in  1  pixel clock enable; all state advances only when high
- hoffset  in  4  signed HS shift in pixels (-8..+7)
- voffset  in  4  signed VS shift in lines (-8..+7)
- hdump  out  9  current H count (H7_BLANK encoding applied)
- vdump  out  9  current line
- vrender  out  9  vdump+VRENDER_AHEAD mod (VCNT_END+1)
- vrender1  out  9  vrender+1 mod (VCNT_END+1)
- hinit  out  1  high while H==HCNT_END
- vinit  out  1  high while H==HCNT_END and V==VCNT_END
- LHBL  out  1  active-low horizontal blank
- LVBL  out  1  active-low vertical blank
- HS  out  1  horizontal sync, active high
- VS  out  1  vertical sync, active high
- irq  out  1  one-clk pulse (coincident with a pxl_cen) at H==0 of line IRQ_LINE
- field  out  1  toggles at every frame wrap

## Operation
- Internal H: 9-bit counter, increments per pxl_cen, wraps HCNT_END -> 0.
- Internal V: increments when H wraps; wraps VCNT_END -> 0.
- hdump = H when H7_BLANK=0; else {H[8], H[7]|H[8], H[6:0]}.
- vrender/vrender1: registered, updated with V; modular add, never exceed VCNT_END.
- LHBL: at pxl_cen with H==HB_START -> 0; H==HB_END -> 1; otherwise holds.
- LVBL: updated only on H wrap: V==VB_START -> 0; V==VB_END -> 1.
- Effective HS points: hs_on = HS_START+hoffset, hs_off = HS_END+hoffset; VS lines vs_on = VS_START+voffset, vs_off = VS_END+voffset. Each sum computed in 10-bit signed, wrapped into [0, CNT_END] by ±(CNT_END+1).
- Offsets captured into shadow registers only on the pxl_cen where vinit=1; mid-frame changes have no effect until next frame.
- HS: H==hs_on -> 1; H==hs_off -> 0.
- VS: evaluated at H==hs_on: V==vs_on -> 1; V==vs_off -> 0.
- If on and off points coincide, the "off" action wins (output stays low).
- irq: asserted for exactly one clk, the cycle after the pxl_cen that makes H=0, V=IRQ_LINE.
- field toggles on the pxl_cen where V wraps to 0.

## Timing
- All outputs registered; update one clk after a pxl_cen. No change on clk edges without pxl_cen.
- Reset (rst_n=0 at a clk edge, regardless of pxl_cen): H=0, V=0, hdump=0, vdump=0, vrender=VRENDER_AHEAD, vrender1=VRENDER_AHEAD+1, hinit=0, vinit=0, LHBL=0, LVBL=0, HS=0, VS=0, irq=0, field=0, offset shadows=0.
- After reset release, LHBL/LVBL remain 0 until their first set point is reached (first HB_END / VB_END).
- Reset mid-frame: same values; counting restarts from H=0,V=0 on the first pxl_cen after release.
- Line period: exactly HCNT_END+1 pxl_cen; frame: (HCNT_END+1)*(VCNT_END+1).
- hinit and vinit combinational from registered counters, no extra latency.

## Test plan
- Reset: hold rst_n=0 mid-frame with pxl_cen toggling -> all outputs at reset values; release -> hdump counts 0,1,2… one per pxl_cen, line = 384 pxl_cen.
- Defaults, one frame: LHBL falls when hdump reaches 256, rises at 0 of next line; LVBL low for lines 239..15; vdump wraps 263 -> 0; field toggles once.
- H7_BLANK=1: H=256 -> hdump=9'h180; H=383 -> 9'h1FF; H=255 -> 9'h0FF.
- Offsets: hoffset=+3 written mid-frame -> HS still rises at H=300 until vinit, then at 303 next frame; hoffset=-8 -> 292; voffset=-3 with VS_END=2 -> VS falls on line 263 (wrap).
- vrender: VRENDER_AHEAD=2 -> vdump=262 gives vrender=0, vrender1=1.
- irq: pulse width exactly 1 clk at line 239 H=0, once per frame; pxl_cen held low -> no state change, no irq.
